// File: rtl/gpio_reg_file.sv
// rtl/gpio_reg_file.sv - GPIO command responder for the micro; RF_GPO_SYNC_EN adds a 2-flop input synchronizer
module gpio_reg_file #(
    parameter int NB_GPIOS        = 32,
    parameter int NB_LEDS         = 4,
    parameter int NB_ADDR_RAM_LOG = 15,
    parameter int NB_DATA_RAM_LOG = 32
) (
    input  logic                       clock,
    input  logic                       i_reset,
    input  logic [NB_GPIOS-1:0]        i_gpo_data,
    output logic [NB_GPIOS-1:0]        o_gpi_data,
    output logic                       o_soft_reset,
    output logic [3:0]                 o_enables,
    output logic [NB_LEDS-1:0]         o_leds,
    output logic                       o_log_run,
    input  logic                       i_log_full,
    output logic [NB_ADDR_RAM_LOG-1:0] o_log_read_addr,
    input  logic [NB_DATA_RAM_LOG-1:0] i_log_read_data
);

    localparam logic [7:0] CMD_NOP           = 8'h00;
    localparam logic [7:0] CMD_SOFT_RESET    = 8'h01;
    localparam logic [7:0] CMD_SET_ENABLES   = 8'h02;
    localparam logic [7:0] CMD_SET_LEDS      = 8'h03;
    localparam logic [7:0] CMD_LOG_RUN       = 8'h04;
    localparam logic [7:0] CMD_READ_STATUS   = 8'h05;
    localparam logic [7:0] CMD_SET_READ_ADDR = 8'h06;
    localparam logic [7:0] CMD_READ_LOG_LO   = 8'h07;
    localparam logic [7:0] CMD_READ_LOG_HI   = 8'h08;

    localparam logic [4:0]  SOFT_RESET_CYCLES = 5'd16;
    localparam logic [23:0] RESP_BAD_CMD      = 24'hEEEEEE;
    // Reset image of the sampled word: strobe looks high so a strobe held
    // through reset release never produces an edge.
    localparam logic [NB_GPIOS-1:0] STROBE_MASK = NB_GPIOS'(32'h0080_0000);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t                       state_q;
    state_t                       state_d;
    logic [NB_GPIOS-1:0]          gpo_smp;
    logic                         strobe;
    logic                         strobe_prev;
    logic                         strobe_edge;
    logic [7:0]                   cmd_q;
    logic [22:0]                  payload_q;
    logic                         ack_q;
    logic [23:0]                  resp_q;
    logic [3:0]                   enables_q;
    logic [NB_LEDS-1:0]           leds_q;
    logic                         log_run_q;
    logic [NB_ADDR_RAM_LOG-1:0]   read_addr_q;
    logic [4:0]                   soft_cnt_q;
    logic [23:0]                  status_word;
    logic [31:0]                  log_data_ext;
    logic                         cmd_is_read;
    logic                         unused_payload;

`ifdef RF_GPO_SYNC_EN
    logic [NB_GPIOS-1:0] gpo_meta;
    logic [NB_GPIOS-1:0] gpo_sync;

    // Two-flop synchronizer for a micro clock asynchronous to clock.
    always_ff @(posedge clock) begin
        if (i_reset) begin
            gpo_meta <= STROBE_MASK;
            gpo_sync <= STROBE_MASK;
        end else begin
            gpo_meta <= i_gpo_data;
            gpo_sync <= gpo_meta;
        end
    end

    assign gpo_smp = gpo_sync;
`else
    assign gpo_smp = i_gpo_data;
`endif

    assign strobe         = gpo_smp[23];
    assign strobe_edge    = strobe & ~strobe_prev;
    assign cmd_is_read    = (cmd_q == CMD_READ_LOG_LO) || (cmd_q == CMD_READ_LOG_HI);
    assign unused_payload = ^payload_q;

    // Status word and RAM data zero-extended to fixed response widths.
    always_comb begin
        status_word = '0;
        status_word[NB_LEDS+4:0] = {i_log_full, enables_q, leds_q};
        log_data_ext = '0;
        log_data_ext[NB_DATA_RAM_LOG-1:0] = i_log_read_data;
    end

    // Command FSM state register.
    always_ff @(posedge clock) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; DONE waits for the registered strobe to read low.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (strobe_edge) state_d = ST_EXEC;
            ST_EXEC: state_d = cmd_is_read ? ST_WAIT : ST_DONE;
            ST_WAIT: state_d = ST_DONE;
            ST_DONE: if (!strobe_prev) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Command latch, execution, response and ack handshake.
    always_ff @(posedge clock) begin
        if (i_reset) begin
            strobe_prev <= 1'b1;
            cmd_q       <= '0;
            payload_q   <= '0;
            ack_q       <= 1'b0;
            resp_q      <= '0;
            enables_q   <= '0;
            leds_q      <= '0;
            log_run_q   <= 1'b0;
            read_addr_q <= '0;
            soft_cnt_q  <= '0;
        end else begin
            strobe_prev <= strobe;
            log_run_q   <= 1'b0;
            if (soft_cnt_q != 5'd0) begin
                soft_cnt_q <= soft_cnt_q - 5'd1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (strobe_edge) begin
                        cmd_q     <= gpo_smp[31:24];
                        payload_q <= gpo_smp[22:0];
                    end
                end
                ST_EXEC: begin
                    if (!cmd_is_read) begin
                        ack_q <= 1'b1;
                    end
                    case (cmd_q)
                        CMD_NOP:           ;
                        CMD_SOFT_RESET:    soft_cnt_q  <= SOFT_RESET_CYCLES;
                        CMD_SET_ENABLES:   enables_q   <= payload_q[3:0];
                        CMD_SET_LEDS:      leds_q      <= payload_q[NB_LEDS-1:0];
                        CMD_LOG_RUN:       log_run_q   <= 1'b1;
                        CMD_READ_STATUS:   resp_q      <= status_word;
                        CMD_SET_READ_ADDR: read_addr_q <= payload_q[NB_ADDR_RAM_LOG-1:0];
                        CMD_READ_LOG_LO,
                        CMD_READ_LOG_HI:   ;
                        default:           resp_q      <= RESP_BAD_CMD;
                    endcase
                end
                ST_WAIT: begin
                    ack_q <= 1'b1;
                    if (cmd_q == CMD_READ_LOG_HI) begin
                        resp_q <= {8'h00, log_data_ext[31:16]};
                    end else begin
                        resp_q <= {8'h00, log_data_ext[15:0]};
                    end
                end
                ST_DONE: begin
                    if (!strobe_prev) begin
                        ack_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_gpi_data      = {ack_q, 7'd0, resp_q};
    assign o_soft_reset    = (soft_cnt_q != 5'd0);
    assign o_enables       = enables_q;
    assign o_leds          = leds_q;
    assign o_log_run       = log_run_q;
    assign o_log_read_addr = read_addr_q;

endmodule

// File: tb/tb_gpio_reg_file.sv
// tb/tb_gpio_reg_file.sv - directed self-checking bench for gpio_reg_file
module tb_gpio_reg_file;

    logic        clock = 1'b0;
    logic        i_reset;
    logic [31:0] i_gpo_data;
    logic [31:0] o_gpi_data;
    logic        o_soft_reset;
    logic [3:0]  o_enables;
    logic [3:0]  o_leds;
    logic        o_log_run;
    logic        i_log_full;
    logic [14:0] o_log_read_addr;
    logic [31:0] i_log_read_data = 32'h0;

    int checks = 0;
    int errors = 0;

    gpio_reg_file dut (
        .clock           (clock),
        .i_reset         (i_reset),
        .i_gpo_data      (i_gpo_data),
        .o_gpi_data      (o_gpi_data),
        .o_soft_reset    (o_soft_reset),
        .o_enables       (o_enables),
        .o_leds          (o_leds),
        .o_log_run       (o_log_run),
        .i_log_full      (i_log_full),
        .o_log_read_addr (o_log_read_addr),
        .i_log_read_data (i_log_read_data)
    );

    always #5 clock = ~clock;

    // Log RAM model with one cycle of read latency.
    always @(posedge clock) begin
        i_log_read_data <= (o_log_read_addr == 15'h0012) ? 32'hCAFE_BEEF : 32'h1234_5678;
    end

    task automatic drive(input logic [7:0] cmd, input logic strb, input logic [22:0] payload);
        i_gpo_data = {cmd, strb, payload};
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        i_gpo_data = 32'h0;
        i_log_full = 1'b0;
        repeat (3) @(negedge clock);
        checks++; if (o_gpi_data !== 32'h0) begin errors++; $display("FAIL reset_gpi: got %h expected %h", o_gpi_data, 32'h0); end
        checks++; if (o_soft_reset !== 1'b0) begin errors++; $display("FAIL reset_soft: got %b expected 0", o_soft_reset); end
        checks++; if (o_enables !== 4'h0) begin errors++; $display("FAIL reset_enables: got %h expected 0", o_enables); end
        checks++; if (o_leds !== 4'h0) begin errors++; $display("FAIL reset_leds: got %h expected 0", o_leds); end
        checks++; if (o_log_run !== 1'b0) begin errors++; $display("FAIL reset_log_run: got %b expected 0", o_log_run); end
        checks++; if (o_log_read_addr !== 15'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", o_log_read_addr); end
        i_reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_set_leds();
        drive(8'h03, 1'b1, 23'h5);
        @(negedge clock);
        checks++; if (o_leds !== 4'h0) begin errors++; $display("FAIL leds_early: got %h expected %h", o_leds, 4'h0); end
        checks++; if (o_gpi_data !== 32'h0) begin errors++; $display("FAIL ack_early: got %h expected %h", o_gpi_data, 32'h0); end
        @(negedge clock);
        checks++; if (o_leds !== 4'h5) begin errors++; $display("FAIL leds_set: got %h expected %h", o_leds, 4'h5); end
        checks++; if (o_gpi_data !== 32'h8000_0000) begin errors++; $display("FAIL leds_ack: got %h expected %h", o_gpi_data, 32'h8000_0000); end
        drive(8'h03, 1'b0, 23'h5);
        @(negedge clock);
        checks++; if (o_gpi_data !== 32'h8000_0000) begin errors++; $display("FAIL ack_hold: got %h expected %h", o_gpi_data, 32'h8000_0000); end
        @(negedge clock);
        checks++; if (o_gpi_data !== 32'h0) begin errors++; $display("FAIL ack_clear: got %h expected %h", o_gpi_data, 32'h0); end
    endtask

    task automatic test_soft_reset();
        int cnt;
        int first;
        int last;
        cnt = 0; first = 0; last = 0;
        drive(8'h01, 1'b1, 23'h0);
        for (int i = 1; i <= 30; i++) begin
            @(negedge clock);
            if (o_soft_reset === 1'b1) begin
                cnt++;
                if (first == 0) first = i;
                last = i;
            end
            if (i == 2) drive(8'h01, 1'b0, 23'h0);
        end
        checks++; if (cnt != 16) begin errors++; $display("FAIL soft_len: got %0d expected %0d", cnt, 16); end
        checks++; if (first != 2) begin errors++; $display("FAIL soft_start: got %0d expected %0d", first, 2); end
        checks++; if (last != 17) begin errors++; $display("FAIL soft_end: got %0d expected %0d", last, 17); end

        cnt = 0; first = 0; last = 0;
        drive(8'h01, 1'b1, 23'h0);
        for (int i = 1; i <= 40; i++) begin
            @(negedge clock);
            if (o_soft_reset === 1'b1) begin
                cnt++;
                if (first == 0) first = i;
                last = i;
            end
            if (i == 2)  drive(8'h01, 1'b0, 23'h0);
            if (i == 10) drive(8'h01, 1'b1, 23'h0);
            if (i == 12) drive(8'h01, 1'b0, 23'h0);
        end
        checks++; if (cnt != 26) begin errors++; $display("FAIL soft_reissue_len: got %0d expected %0d", cnt, 26); end
        checks++; if (last != 27) begin errors++; $display("FAIL soft_reissue_end: got %0d expected %0d", last, 27); end
    endtask

    task automatic test_read_log();
        drive(8'h06, 1'b1, 23'h12);
        repeat (2) @(negedge clock);
        checks++; if (o_log_read_addr !== 15'h0012) begin errors++; $display("FAIL read_addr: got %h expected %h", o_log_read_addr, 15'h0012); end
        checks++; if (o_gpi_data !== 32'h8000_0000) begin errors++; $display("FAIL read_addr_ack: got %h expected %h", o_gpi_data, 32'h8000_0000); end
        drive(8'h06, 1'b0, 23'h12);
        repeat (2) @(negedge clock);

        drive(8'h07, 1'b1, 23'h0);
        repeat (2) @(negedge clock);
        checks++; if (o_gpi_data !== 32'h0) begin errors++; $display("FAIL read_lo_early: got %h expected %h", o_gpi_data, 32'h0); end
        @(negedge clock);
        checks++; if (o_gpi_data !== 32'h8000_BEEF) begin errors++; $display("FAIL read_lo: got %h expected %h", o_gpi_data, 32'h8000_BEEF); end
        drive(8'h07, 1'b0, 23'h0);
        repeat (2) @(negedge clock);

        drive(8'h08, 1'b1, 23'h0);
        repeat (3) @(negedge clock);
        checks++; if (o_gpi_data !== 32'h8000_CAFE) begin errors++; $display("FAIL read_hi: got %h expected %h", o_gpi_data, 32'h8000_CAFE); end
        drive(8'h08, 1'b0, 23'h0);
        repeat (2) @(negedge clock);
        checks++; if (o_gpi_data !== 32'h0000_CAFE) begin errors++; $display("FAIL read_hi_hold: got %h expected %h", o_gpi_data, 32'h0000_CAFE); end
    endtask

    task automatic test_status();
        drive(8'h02, 1'b1, 23'hA);
        repeat (2) @(negedge clock);
        checks++; if (o_enables !== 4'hA) begin errors++; $display("FAIL enables: got %h expected %h", o_enables, 4'hA); end
        drive(8'h02, 1'b0, 23'hA);
        repeat (2) @(negedge clock);
        i_log_full = 1'b1;
        drive(8'h05, 1'b1, 23'h0);
        repeat (2) @(negedge clock);
        checks++; if (o_gpi_data !== 32'h8000_01A5) begin errors++; $display("FAIL status: got %h expected %h", o_gpi_data, 32'h8000_01A5); end
        drive(8'h05, 1'b0, 23'h0);
        repeat (2) @(negedge clock);
        checks++; if (o_gpi_data !== 32'h0000_01A5) begin errors++; $display("FAIL status_hold: got %h expected %h", o_gpi_data, 32'h0000_01A5); end
        i_log_full = 1'b0;
    endtask

    task automatic test_log_run();
        drive(8'h04, 1'b1, 23'h0);
        @(negedge clock);
        checks++; if (o_log_run !== 1'b0) begin errors++; $display("FAIL log_run_early: got %b expected 0", o_log_run); end
        @(negedge clock);
        checks++; if (o_log_run !== 1'b1) begin errors++; $display("FAIL log_run_pulse: got %b expected 1", o_log_run); end
        checks++; if (o_gpi_data !== 32'h8000_01A5) begin errors++; $display("FAIL log_run_ack: got %h expected %h", o_gpi_data, 32'h8000_01A5); end
        drive(8'h04, 1'b0, 23'h0);
        @(negedge clock);
        checks++; if (o_log_run !== 1'b0) begin errors++; $display("FAIL log_run_width: got %b expected 0", o_log_run); end
        @(negedge clock);
    endtask

    task automatic test_nop();
        drive(8'h00, 1'b1, 23'h7F);
        repeat (2) @(negedge clock);
        checks++; if (o_gpi_data !== 32'h8000_01A5) begin errors++; $display("FAIL nop_ack: got %h expected %h", o_gpi_data, 32'h8000_01A5); end
        drive(8'h00, 1'b0, 23'h7F);
        repeat (2) @(negedge clock);
        checks++; if (o_gpi_data !== 32'h0000_01A5) begin errors++; $display("FAIL nop_clear: got %h expected %h", o_gpi_data, 32'h0000_01A5); end
    endtask

    task automatic test_bad_cmd();
        drive(8'h3F, 1'b1, 23'h0);
        repeat (2) @(negedge clock);
        checks++; if (o_gpi_data !== 32'h80EE_EEEE) begin errors++; $display("FAIL bad_cmd: got %h expected %h", o_gpi_data, 32'h80EE_EEEE); end
        drive(8'h03, 1'b0, 23'hF);
        @(negedge clock);
        checks++; if (o_gpi_data !== 32'h80EE_EEEE) begin errors++; $display("FAIL bad_cmd_hold: got %h expected %h", o_gpi_data, 32'h80EE_EEEE); end
        drive(8'h03, 1'b1, 23'hF);
        @(negedge clock);
        checks++; if (o_gpi_data !== 32'h00EE_EEEE) begin errors++; $display("FAIL bad_cmd_clear: got %h expected %h", o_gpi_data, 32'h00EE_EEEE); end
        repeat (3) @(negedge clock);
        checks++; if (o_leds !== 4'h5) begin errors++; $display("FAIL done_toggle_leds: got %h expected %h", o_leds, 4'h5); end
        checks++; if (o_gpi_data !== 32'h00EE_EEEE) begin errors++; $display("FAIL done_toggle_gpi: got %h expected %h", o_gpi_data, 32'h00EE_EEEE); end
        drive(8'h03, 1'b0, 23'hF);
        repeat (2) @(negedge clock);
    endtask

    task automatic test_reset_abort();
        drive(8'h07, 1'b1, 23'h0);
        repeat (2) @(negedge clock);
        i_reset = 1'b1;
        drive(8'h03, 1'b1, 23'hF);
        @(negedge clock);
        checks++; if (o_gpi_data !== 32'h0) begin errors++; $display("FAIL abort_gpi: got %h expected %h", o_gpi_data, 32'h0); end
        checks++; if (o_enables !== 4'h0) begin errors++; $display("FAIL abort_enables: got %h expected %h", o_enables, 4'h0); end
        checks++; if (o_leds !== 4'h0) begin errors++; $display("FAIL abort_leds: got %h expected %h", o_leds, 4'h0); end
        checks++; if (o_log_read_addr !== 15'h0) begin errors++; $display("FAIL abort_addr: got %h expected %h", o_log_read_addr, 15'h0); end
        @(negedge clock);
        i_reset = 1'b0;
        repeat (4) @(negedge clock);
        checks++; if (o_leds !== 4'h0) begin errors++; $display("FAIL held_strobe_leds: got %h expected %h", o_leds, 4'h0); end
        checks++; if (o_gpi_data !== 32'h0) begin errors++; $display("FAIL held_strobe_gpi: got %h expected %h", o_gpi_data, 32'h0); end
        drive(8'h03, 1'b0, 23'hF);
        repeat (2) @(negedge clock);
        drive(8'h03, 1'b1, 23'hF);
        repeat (2) @(negedge clock);
        checks++; if (o_leds !== 4'hF) begin errors++; $display("FAIL post_reset_leds: got %h expected %h", o_leds, 4'hF); end
        checks++; if (o_gpi_data !== 32'h8000_0000) begin errors++; $display("FAIL post_reset_ack: got %h expected %h", o_gpi_data, 32'h8000_0000); end
        drive(8'h03, 1'b0, 23'hF);
        repeat (2) @(negedge clock);
        checks++; if (o_gpi_data !== 32'h0) begin errors++; $display("FAIL post_reset_clear: got %h expected %h", o_gpi_data, 32'h0); end
    endtask

    initial begin
        i_reset = 1'b1;
        i_gpo_data = 32'h0;
        i_log_full = 1'b0;
        test_reset();
        test_set_leds();
        test_soft_reset();
        test_read_log();
        test_status();
        test_log_run();
        test_nop();
        test_bad_cmd();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
